// File: rtl/shift_add_mult8.sv
// 8x8 unsigned shift-and-add multiplier: one adder8 pass per RUN cycle,
// eight iterations, then a one-cycle DONE pulse with the 16-bit product.

module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

module shift_add_mult8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        done,
    output logic [15:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic [7:0]  acc;
    logic [2:0]  cnt;
    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        cout;

    assign addend = mplier[0] ? mcand : 8'd0;

    adder8 u_adder (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The adder carry is shifted straight into acc[7], so it needs no
    // storage of its own between iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= 8'd0;
            mplier <= 8'd0;
            acc    <= 8'd0;
            cnt    <= 3'd0;
            p      <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= 8'd0;
                        cnt    <= 3'd0;
                    end
                end
                RUN: begin
                    acc    <= {cout, sum[7:1]};
                    mplier <= {sum[0], mplier[7:1]};
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        p <= {cout, sum, mplier[7:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult8.sv
// Bench for shift_add_mult8: a cycle-level behavioural model checked every
// cycle, plus directed operations with hand-computed products and latencies.

module tb_shift_add_mult8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        done;
    logic [15:0] p;

    shift_add_mult8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    // Model: phase 0 = idle, 1..8 = edges seen since accept, 9 = done cycle.
    int          phase = 0;
    logic [15:0] op_p  = 16'd0;
    logic [15:0] exp_p = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            phase = 0;
            exp_p = 16'd0;
        end else if (phase == 0) begin
            if (start) begin
                op_p  = 16'(a) * 16'(b);
                phase = 1;
            end
        end else if (phase == 9) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == 9) exp_p = op_p;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ready", ready, phase == 0);
            check("model_done", done, phase == 9);
            check("model_p", p, exp_p);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] expv);
        int n;
        int d0;
        tick();
        a     = aa;
        b     = bb;
        start = 1'b1;
        d0    = done_cnt;
        tick();
        start = 1'b0;
        n     = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, 8);
        check("p_literal", p, expv);
        tick();
        check("ready_after_done", ready, 1);
        check("single_done", done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vp;
    } vec_t;

    vec_t vecs[8] = '{
        '{8'd3,   8'd5,   16'd15},
        '{8'd200, 8'd100, 16'd20000},
        '{8'd255, 8'd255, 16'd65025},
        '{8'd0,   8'd173, 16'd0},
        '{8'd173, 8'd0,   16'd0},
        '{8'd1,   8'd255, 16'd255},
        '{8'd128, 8'd2,   16'd256},
        '{8'd7,   8'd9,   16'd63}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        int t_done[$];

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        tick();
        cmp_en = 1'b1;
        // Reset and start together must not accept anything.
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        tick();
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_p", p, 16'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("idle_ready", ready, 1);

        foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].vp);

        // Second start and operand change during RUN are ignored.
        tick();
        a     = 8'd8;
        b     = 8'd5;
        start = 1'b1;
        d0    = done_cnt;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("busy_ready", ready, 0);
        start = 1'b1;
        a     = 8'd99;
        tick();
        start = 1'b0;
        n     = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("ignore_start_p", p, 16'd40);
        repeat (15) tick();
        check("ignore_start_dones", done_cnt - d0, 1);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        a     = 8'd200;
        b     = 8'd100;
        start = 1'b1;
        d0    = done_cnt;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_p", p, 16'd0);
        check("abort_done", done, 0);
        repeat (12) tick();
        check("abort_no_done", done_cnt - d0, 0);
        run_op(8'd7, 8'd9, 16'd63);

        // Start held high: one operation every 10 cycles.
        a     = 8'd10;
        b     = 8'd12;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 25) start = 1'b0;
            tick();
            if (done) begin
                t_done.push_back(cyc);
                check("b2b_p", p, 16'd120);
            end
        end
        check("b2b_count", t_done.size(), 3);
        for (int k = 1; k < t_done.size(); k++) begin
            check("b2b_gap", t_done[k] - t_done[k-1], 10);
        end
        check("b2b_idle", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult8.md
SHIFT_ADD_MULT8 -- requirements
Module: shift_add_mult8

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits to match adder8.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiplication; sampled only while ready=1.
REQ-005 a  input  8  unsigned multiplicand; captured on the accepting edge.
REQ-006 b  input  8  unsigned multiplier; captured on the accepting edge.
REQ-007 ready  output  1  high while idle; start is accepted only in this state.
REQ-008 done  output  1  one-cycle pulse; p holds a new valid product in the same cycle.
REQ-009 p  output  16  unsigned product a*b; held until the next completion.

Function
REQ-010 The block SHALL implement a shift-and-add multiplier whose partial-product addition goes through one instance of adder8 with cin tied to 0.
REQ-011 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
- ready=1 only in IDLE.
- done=1 only in DONE.
REQ-012 IDLE with start=1 at an edge:
- capture a into the multiplicand register and b into the multiplier register;
- clear the 8-bit upper accumulator, the carry bit and the 3-bit iteration counter;
- go to RUN.
REQ-013 IDLE with start=0 SHALL stay in IDLE with all registers and p unchanged.
REQ-014 Each RUN edge SHALL perform exactly one iteration:
- adder inputs = accumulator and (multiplier LSB ? multiplicand : 0);
- {adder carry, adder sum, multiplier} is shifted right by one into {accumulator, multiplier};
- counter increments.
REQ-015 On the RUN edge where the counter is 7 (the 8th iteration), the block SHALL load p with the final {accumulator, multiplier} value and go to DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge E0, done SHALL be high between edges E8 and E9, and ready SHALL return high after E9.
REQ-018 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-019 Changes on a or b after the accepting edge SHALL NOT affect the result in progress.
REQ-020 The product SHALL be exact for all 65536 operand pairs; maximum 255*255=65025 fits 16 bits with no overflow.
REQ-021 p SHALL change only on the edge that enters DONE, or on reset.
REQ-022 Back-to-back operation: start held high continuously SHALL produce one accepted operation every 10 cycles (accept, 8 RUN, DONE).

Reset
REQ-023 When rst=1 at an edge, the state SHALL become IDLE and p, accumulator, multiplier, multiplicand, carry and counter SHALL be cleared to 0.
REQ-024 Output values after reset SHALL be ready=1, done=0, p=16'd0.
REQ-025 rst SHALL take priority over start and over any in-progress iteration.
REQ-026 Reset mid-RUN SHALL abort the operation with no done pulse and p=0.
REQ-027 rst and start high at the same edge SHALL leave the block in IDLE with nothing accepted.

Verification
REQ-028 a=3, b=5, start pulsed one cycle from IDLE -> done high exactly 8 cycles after the accepting edge, p=16'd15; ready=0 during RUN and DONE.
REQ-029 a=200, b=100 -> p=16'd20000 (16'h4E20); a=255, b=255 -> p=16'd65025 (16'hFE01).
REQ-030 a=0, b=173, then a=173, b=0 -> p=0 both times, each with a single done pulse.
REQ-031 Start a=8, b=5; pulse start again and change a to 99 at the 3rd RUN cycle -> exactly one done, p=16'd40.
REQ-032 Start a=200, b=100; assert rst at the 4th RUN cycle -> no done pulse, p=0, ready=1 on the next cycle; a fresh 7*9 then yields p=16'd63.
REQ-033 start held high for 25 cycles with a=10, b=12 -> done pulses 10 cycles apart, each with p=16'd120.
